// File: rtl/multicycle_subtractor.sv
// Sequential WIDTH-bit subtractor, CHUNK bits per cycle with a carried borrow.
// Define SUB_ABS_EN to add a FIX cycle that turns the result into |a-b| with a sign bit.
module multicycle_subtractor #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   d
);

  localparam int N  = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("multicycle_subtractor: WIDTH must be >=1 and a multiple of CHUNK");
    end
  endgenerate

`ifdef SUB_ABS_EN
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic             borrow_reg;
  logic [IW-1:0]    idx_reg;
  logic [WIDTH:0]   d_reg;
  logic             done_reg;

  logic load, step, last, fix;

  // Operands are shifted right each cycle so the active chunk is always at bit 0.
  logic [CHUNK-1:0] diff_chunk;
  logic [CHUNK:0]   bw;

  assign bw[0] = borrow_reg;

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fs
      assign diff_chunk[gi] = a_reg[gi] ^ b_reg[gi] ^ bw[gi];
      assign bw[gi+1]       = (~a_reg[gi] & b_reg[gi]) | (bw[gi] & ~(a_reg[gi] ^ b_reg[gi]));
    end
  endgenerate

  // New chunk enters at the top; after N steps chunk 0 has reached bit 0.
  logic [WIDTH+CHUNK-1:0] res_cat;
  logic [WIDTH-1:0]       res_next;

  assign res_cat  = {diff_chunk, res_reg} >> CHUNK;
  assign res_next = res_cat[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    fix        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (idx_reg == IW'(N - 1)) begin
          last = 1'b1;
`ifdef SUB_ABS_EN
          state_next = FIX;
`else
          state_next = IDLE;
`endif
        end
      end
`ifdef SUB_ABS_EN
      FIX: begin
        fix        = 1'b1;
        state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      borrow_reg <= 1'b0;
      idx_reg    <= '0;
      d_reg      <= '0;
      done_reg   <= 1'b0;
    end else begin
      if (load) begin
        a_reg      <= a;
        b_reg      <= b;
        borrow_reg <= 1'b0;
        idx_reg    <= '0;
      end
      if (step) begin
        a_reg      <= a_reg >> CHUNK;
        b_reg      <= b_reg >> CHUNK;
        res_reg    <= res_next;
        borrow_reg <= bw[CHUNK];
        idx_reg    <= last ? '0 : idx_reg + IW'(1);
      end
      if (last) d_reg <= {bw[CHUNK], res_next};
      if (fix && d_reg[WIDTH]) d_reg[WIDTH-1:0] <= ~d_reg[WIDTH-1:0] + WIDTH'(1);
`ifdef SUB_ABS_EN
      done_reg <= fix;
`else
      done_reg <= last;
`endif
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign d    = d_reg;

endmodule

// File: tb/tb_multicycle_subtractor.sv
// Directed/table-driven bench for multicycle_subtractor at CHUNK=4, 1 and 8 (WIDTH=8).
// Honours SUB_ABS_EN when the bundle is built with it.
module tb_multicycle_subtractor;

`ifdef SUB_ABS_EN
  localparam int ABS = 1;
`else
  localparam int ABS = 0;
`endif
  localparam int LAT0 = 2 + ABS;
  localparam int LAT1 = 8 + ABS;
  localparam int LAT2 = 1 + ABS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, start1, start2;
  logic [7:0] a, b;
  logic       busy0, busy1, busy2, done0, done1, done2;
  logic [8:0] d0, d1, d2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_subtractor #(.WIDTH(8), .CHUNK(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a), .b(b), .busy(busy0), .done(done0), .d(d0));
  multicycle_subtractor #(.WIDTH(8), .CHUNK(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b), .busy(busy1), .done(done1), .d(d1));
  multicycle_subtractor #(.WIDTH(8), .CHUNK(8)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a), .b(b), .busy(busy2), .done(done2), .d(d2));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] d_plain;
    logic [8:0] d_abs;
  } vec_t;

  vec_t vecs[8];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [8:0] model(logic [7:0] x, logic [7:0] y);
    logic [8:0] r;
    r = {1'b0, x} - {1'b0, y};
    if (ABS == 1 && r[8]) r[7:0] = y - x;
    return r;
  endfunction

  // Start all three instances together and watch a fixed window after the accepting edge.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [8:0] e);
    int lat0, lat1, lat2, busy_cnt, done_cnt;
    logic [8:0] v0, v1, v2;
    lat0 = -1; lat1 = -1; lat2 = -1; busy_cnt = 0; done_cnt = 0;
    v0 = '0; v1 = '0; v2 = '0;
    @(negedge clk);
    a = ta; b = tb_v; start0 = 1'b1; start1 = 1'b1; start2 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    a = ~ta; b = ~tb_v;
    for (int c = 0; c < 16; c++) begin
      if (busy0) busy_cnt++;
      if (done0) done_cnt++;
      if (done0 && lat0 < 0) begin lat0 = c; v0 = d0; end
      if (done1 && lat1 < 0) begin lat1 = c; v1 = d1; end
      if (done2 && lat2 < 0) begin lat2 = c; v2 = d2; end
      @(negedge clk);
    end
    $display("op a=%02h b=%02h exp=%03h d4=%03h d1=%03h d8=%03h lat=%0d/%0d/%0d",
             ta, tb_v, e, v0, v1, v2, lat0, lat1, lat2);
    check("lat_c4", lat0, LAT0);
    check("d_c4", v0, e);
    check("busy_cycles_c4", busy_cnt, LAT0);
    check("done_pulses_c4", done_cnt, 1);
    check("d_hold_c4", d0, e);
    check("lat_c1", lat1, LAT1);
    check("d_c1", v1, e);
    check("lat_c8", lat2, LAT2);
    check("d_c8", v2, e);
  endtask

  task automatic wait_done0(output int cyc);
    cyc = 0;
    while (!done0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc, done_seen;
    logic [7:0] ra, rb;

    vecs[0] = '{8'h9A, 8'h35, 9'h065, 9'h065};
    vecs[1] = '{8'h10, 8'h20, 9'h1F0, 9'h110};
    vecs[2] = '{8'h00, 8'hFF, 9'h101, 9'h1FF};
    vecs[3] = '{8'hFF, 8'hFF, 9'h000, 9'h000};
    vecs[4] = '{8'h05, 8'h03, 9'h002, 9'h002};
    vecs[5] = '{8'h00, 8'h01, 9'h1FF, 9'h101};
    vecs[6] = '{8'hFF, 8'h00, 9'h0FF, 9'h0FF};
    vecs[7] = '{8'h7F, 8'h80, 9'h1FF, 9'h101};

    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; a = '0; b = '0;
    #3;
    check("reset_busy", {busy0, busy1, busy2}, 3'b000);
    check("reset_done", {done0, done1, done2}, 3'b000);
    check("reset_d0", d0, 9'h000);
    check("reset_d1", d1, 9'h000);
    check("reset_d2", d2, 9'h000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, (ABS == 1) ? vecs[i].d_abs : vecs[i].d_plain);

    // Ignored start while busy, then a back-to-back start in the done cycle.
    @(negedge clk);
    a = 8'h9A; b = 8'h35; start0 = 1'b1;
    @(negedge clk);
    a = 8'h00; b = 8'h01;
    @(negedge clk);
    start0 = 1'b0;
    wait_done0(cyc);
    $display("b2b first: d=%03h lat=%0d", d0, cyc + 1);
    check("b2b_first_lat", cyc + 1, LAT0);
    check("b2b_first_d", d0, 9'h065);
    a = 8'h05; b = 8'h03; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("b2b_accepted_busy", busy0, 1'b1);
    check("b2b_d_held", d0, 9'h065);
    wait_done0(cyc);
    $display("b2b second: d=%03h lat=%0d", d0, cyc);
    check("b2b_second_lat", cyc, LAT0);
    check("b2b_second_d", d0, 9'h002);
    repeat (3) @(negedge clk);
    check("idle_d_hold", d0, 9'h002);
    check("idle_done_low", done0, 1'b0);

    // Reset during the first RUN cycle aborts the operation.
    @(negedge clk);
    a = 8'h9A; b = 8'h35; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy0, 1'b0);
    check("midrst_done", done0, 1'b0);
    check("midrst_d", d0, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (done0) done_seen++;
      @(negedge clk);
    end
    $display("midrst: done pulses after abort=%0d d=%03h", done_seen, d0);
    check("midrst_no_done", done_seen, 0);
    check("midrst_d_after", d0, 9'h000);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra, rb, model(ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
